// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, ROM port, IF/ID register and status out.
// The slave modport is the fetch stage; the master modport is its environment (ID, hazard unit, ROM).
interface if_stage_if #(
    parameter int ROM_AW = 10
);
    logic              stall;
    logic              flush;
    logic [1:0]        npc_sel;
    logic              br_taken;
    logic [31:0]       jr_target;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic [31:0]       pc_f;
    logic [31:0]       instr_d;
    logic [31:0]       pc_d;
    logic [31:0]       pc4_d;
    logic              valid_d;
    logic              fetch_err;
    logic [31:0]       fetch_cnt;

    modport master (
        output stall, flush, npc_sel, br_taken, jr_target, rom_data,
        input  rom_addr, pc_f, instr_d, pc_d, pc4_d, valid_d, fetch_err, fetch_cnt
    );

    modport slave (
        input  stall, flush, npc_sel, br_taken, jr_target, rom_data,
        output rom_addr, pc_f, instr_d, pc_d, pc4_d, valid_d, fetch_err, fetch_cnt
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux driven by ID-stage decisions,
// combinational ROM addressing and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          ROM_AW   = 10
) (
    input logic       clk,
    input logic       reset,
    if_stage_if.slave bus
);
    logic [31:0] r_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc4_d;
    logic        r_valid_d;
    logic [31:0] r_fetch_cnt;

    logic [31:0] w_pc_off;
    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_npc;
    logic        w_fetch_err;

    assign w_pc_off = r_pc - PC_RESET;
    assign w_pc4    = r_pc + 32'd4;
    assign w_br_off = {{14{r_instr_d[15]}}, r_instr_d[15:0], 2'b00};

    // The instruction space is word-aligned at PC_RESET and does not wrap past 2^32,
    // so an offset below 4*2^ROM_AW with clear low bits is exactly "aligned and in range".
    assign w_fetch_err = (w_pc_off[1:0] != 2'b00) || (w_pc_off[31:ROM_AW+2] != '0);

    always_comb begin
        w_npc = w_pc4;
        case (bus.npc_sel)
            2'b01:   w_npc = bus.br_taken ? (r_pc4_d + w_br_off) : w_pc4;
            2'b10:   w_npc = {r_pc4_d[31:28], r_instr_d[25:0], 2'b00};
            2'b11:   w_npc = bus.jr_target;
            default: w_npc = w_pc4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= PC_RESET;
            r_instr_d   <= '0;
            r_pc_d      <= PC_RESET;
            r_pc4_d     <= PC_RESET + 32'd4;
            r_valid_d   <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            if (!bus.stall) begin
                r_pc <= w_npc;
            end

            if (bus.flush) begin
                r_instr_d <= '0;
                r_valid_d <= 1'b0;
                if (!bus.stall) begin
                    r_pc_d  <= r_pc;
                    r_pc4_d <= w_pc4;
                end
            end else if (!bus.stall) begin
                r_pc_d  <= r_pc;
                r_pc4_d <= w_pc4;
                if (!w_fetch_err) begin
                    r_instr_d   <= bus.rom_data;
                    r_valid_d   <= 1'b1;
                    r_fetch_cnt <= r_fetch_cnt + 32'd1;
                end else begin
                    r_instr_d <= '0;
                    r_valid_d <= 1'b0;
                end
            end
        end
    end

    assign bus.rom_addr  = w_pc_off[ROM_AW+1:2];
    assign bus.pc_f      = r_pc;
    assign bus.instr_d   = r_instr_d;
    assign bus.pc_d      = r_pc_d;
    assign bus.pc4_d     = r_pc4_d;
    assign bus.valid_d   = r_valid_d;
    assign bus.fetch_err = w_fetch_err;
    assign bus.fetch_cnt = r_fetch_cnt;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, branch/jump/jr redirects with delay slot,
// stall/flush interaction, out-of-range fetches and asynchronous reset.
module tb_if_stage;
    localparam int ROM_AW = 10;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [31:0] rom [0:(1<<ROM_AW)-1];

    if_stage_if #(.ROM_AW(ROM_AW)) bus ();

    if_stage #(.PC_RESET(32'h0000_3000), .ROM_AW(ROM_AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ctl(input logic st, input logic fl, input logic [1:0] sel,
                           input logic bt, input logic [31:0] jt);
        bus.stall     = st;
        bus.flush     = fl;
        bus.npc_sel   = sel;
        bus.br_taken  = bt;
        bus.jr_target = jt;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < (1 << ROM_AW); i++) rom[i] = 32'hC000_0000 | 32'(i);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_ctl(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        fill_rom();
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
        reset = 1'b0;
        set_ctl(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        @(negedge clk);

        // reset state
        check("rst_pc_f",   bus.pc_f,      32'h3000);
        check("rst_pc_d",   bus.pc_d,      32'h3000);
        check("rst_pc4_d",  bus.pc4_d,     32'h3004);
        check("rst_instr",  bus.instr_d,   32'h0);
        check("rst_valid",  32'(bus.valid_d), 32'h0);
        check("rst_cnt",    bus.fetch_cnt, 32'h0);
        check("rst_err",    32'(bus.fetch_err), 32'h0);
        reset = 1'b1;

        // sequential fetch
        for (int k = 0; k < 4; k++) begin
            check("seq_rom_addr", 32'(bus.rom_addr), 32'(k));
            step();
            check("seq_instr", bus.instr_d, 32'h11 * 32'(k + 1));
            check("seq_pc_d",  bus.pc_d,    32'h3000 + 32'(4 * k));
            check("seq_valid", 32'(bus.valid_d), 32'h1);
        end
        check("seq_cnt",  bus.fetch_cnt, 32'd4);
        check("seq_pc_f", bus.pc_f,      32'h3010);

        // taken branch with delay slot
        fill_rom();
        rom[0] = 32'h0; rom[1] = 32'h1000_FFFF; rom[2] = 32'hAAAA_0002;
        do_reset();
        step();
        step();
        check("br_instr_id", bus.instr_d, 32'h1000_FFFF);
        check("br_pc4_d",    bus.pc4_d,   32'h3008);
        set_ctl(1'b0, 1'b0, 2'b01, 1'b1, 32'h0);
        step();
        check("br_delay_instr", bus.instr_d, 32'hAAAA_0002);
        check("br_delay_pc_d",  bus.pc_d,    32'h3008);
        check("br_target",      bus.pc_f,    32'h3004);
        set_ctl(1'b0, 1'b0, 2'b01, 1'b0, 32'h0);
        step();
        check("br_not_taken", bus.pc_f, 32'h3008);

        // j then jr
        fill_rom();
        rom[0] = 32'h0800_0C10;
        do_reset();
        step();
        check("j_instr_id", bus.instr_d, 32'h0800_0C10);
        set_ctl(1'b0, 1'b0, 2'b10, 1'b0, 32'h0);
        step();
        check("j_target",     bus.pc_f,            32'h3040);
        check("j_rom_addr",   32'(bus.rom_addr),   32'h010);
        check("j_delay_slot", bus.instr_d,         32'hC000_0001);
        set_ctl(1'b0, 1'b0, 2'b11, 1'b0, 32'h3100);
        step();
        check("jr_target",   bus.pc_f,          32'h3100);
        check("jr_rom_addr", 32'(bus.rom_addr), 32'h040);
        check("jr_instr",    bus.instr_d,       32'hC000_0010);
        set_ctl(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        step();
        check("pre_stall_instr", bus.instr_d,   32'hC000_0040);
        check("pre_stall_cnt",   bus.fetch_cnt, 32'd4);

        // stall for three cycles, then stall+flush, then flush alone
        set_ctl(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) step();
        check("stall_pc_f",  bus.pc_f,      32'h3104);
        check("stall_instr", bus.instr_d,   32'hC000_0040);
        check("stall_pc_d",  bus.pc_d,      32'h3100);
        check("stall_cnt",   bus.fetch_cnt, 32'd4);
        set_ctl(1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        step();
        check("stfl_pc_f",  bus.pc_f,         32'h3104);
        check("stfl_instr", bus.instr_d,      32'h0);
        check("stfl_valid", 32'(bus.valid_d), 32'h0);
        check("stfl_pc_d",  bus.pc_d,         32'h3100);
        set_ctl(1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        step();
        check("fl_pc_d",  bus.pc_d,      32'h3104);
        check("fl_pc4_d", bus.pc4_d,     32'h3108);
        check("fl_pc_f",  bus.pc_f,      32'h3108);
        check("fl_cnt",   bus.fetch_cnt, 32'd4);

        // out-of-range and misaligned fetches
        set_ctl(1'b0, 1'b0, 2'b11, 1'b0, 32'h4000);
        step();
        check("oor_err",  32'(bus.fetch_err), 32'h1);
        check("oor_cnt0", bus.fetch_cnt,      32'd5);
        set_ctl(1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        step();
        check("oor_instr", bus.instr_d,         32'h0);
        check("oor_valid", 32'(bus.valid_d),    32'h0);
        check("oor_cnt",   bus.fetch_cnt,       32'd5);
        check("oor_pc_d",  bus.pc_d,            32'h4000);
        set_ctl(1'b0, 1'b0, 2'b11, 1'b0, 32'h3002);
        step();
        check("misalign_err", 32'(bus.fetch_err), 32'h1);
        set_ctl(1'b0, 1'b0, 2'b11, 1'b0, 32'h3FFC);
        step();
        check("last_word_err",  32'(bus.fetch_err), 32'h0);
        check("last_word_addr", 32'(bus.rom_addr),  32'h3FF);
        set_ctl(1'b0, 1'b0, 2'b11, 1'b0, 32'h2FFC);
        step();
        check("below_err",      32'(bus.fetch_err), 32'h1);
        check("last_word_inst", bus.instr_d,        32'hC000_03FF);
        check("last_word_cnt",  bus.fetch_cnt,      32'd6);
        set_ctl(1'b0, 1'b0, 2'b11, 1'b0, 32'h3020);
        step();
        check("pre_areset_pc", bus.pc_f, 32'h3020);

        // asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("areset_pc_f",  bus.pc_f,         32'h3000);
        check("areset_valid", 32'(bus.valid_d), 32'h0);
        check("areset_cnt",   bus.fetch_cnt,    32'h0);
        check("areset_pc4_d", bus.pc4_d,        32'h3004);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the P5 pipelined MIPS core.
- Owns the PC register and the next-PC selection.
- Drives the word address into the instruction ROM and captures the returned instruction into the IF/ID pipeline register.
- Branch and jump decisions come from the ID stage, which uses this block's registered outputs. The architectural delay slot falls out naturally from this arrangement.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset and base address of instruction memory.
- ROM_AW, 10, ROM word-address width; instruction space is 2^ROM_AW words (4 KiB by default).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- stall  input  1  hazard-unit stall: hold PC and IF/ID
- flush  input  1  clear IF/ID to a bubble
- npc_sel  input  2  00 = PC+4, 01 = branch, 10 = j/jal, 11 = jr (asserted by ID)
- br_taken  input  1  branch condition true (only used when npc_sel = 01)
- jr_target  input  32  forwarded rs value for jr/jalr
- rom_addr  output  ROM_AW  word address to instruction ROM
- rom_data  input  32  instruction from ROM (combinational read)
- pc_f  output  32  current fetch PC
- instr_d  output  32  IF/ID instruction
- pc_d  output  32  IF/ID PC
- pc4_d  output  32  IF/ID PC+4
- valid_d  output  1  IF/ID holds a real instruction
- fetch_err  output  1  current pc_f outside instruction space or misaligned (combinational)
- fetch_cnt  output  32  count of instructions delivered into IF/ID

Behaviour:
- Reset (reset = 0, asynchronous), all outputs take these values immediately:
  - pc_f = PC_RESET, pc_d = PC_RESET, pc4_d = PC_RESET + 4
  - instr_d = 0, valid_d = 0, fetch_cnt = 0
- rom_addr = (pc_f - PC_RESET)[ROM_AW+1:2]. The ROM read is combinational, so rom_data is valid in the same cycle and the fetch latency into IF/ID is 1 cycle.
- fetch_err = 1 when any of the following holds; otherwise 0:
  - pc_f[1:0] != 0
  - pc_f < PC_RESET
  - pc_f >= PC_RESET + 4·2^ROM_AW
- Next-PC selection; the imm16 and index fields are taken from instr_d, not rom_data:
  - 00 -> pc_f + 4
  - 01 -> pc4_d + (sign_ext(instr_d[15:0]) << 2) if br_taken, else pc_f + 4
  - 10 -> {pc4_d[31:28], instr_d[25:0], 2'b00}
  - 11 -> jr_target
- All address arithmetic is 32-bit, wrapping modulo 2^32, with no overflow detection.
- Each rising edge, priority flush > stall > normal:
  - PC: if stall, hold pc_f; else pc_f <= next PC. flush does not affect the PC.
  - IF/ID when flush: instr_d <= 0, valid_d <= 0; pc_d and pc4_d are loaded with pc_f and pc_f + 4 when not stalled, otherwise held. fetch_cnt does not increment.
  - IF/ID when stall (and no flush): all IF/ID outputs and fetch_cnt hold.
  - IF/ID normal: pc_d <= pc_f, pc4_d <= pc_f + 4.
    - If fetch_err = 0: instr_d <= rom_data, valid_d <= 1, fetch_cnt increments by 1 (wrap at 2^32).
    - If fetch_err = 1: instr_d <= 0 (nop), valid_d <= 0, fetch_cnt holds.
- Delay slot: a branch or jump in ID redirects the PC, but the instruction fetched in that same cycle (the delay slot) still enters IF/ID. The block never squashes it itself; only an external flush does.
- Stall with a redirect: while stall = 1, the ID instruction and npc_sel stay stable, so the redirect takes effect on the first unstalled edge.
- Reset released mid-cycle: the first fetch is at PC_RESET on the first edge after reset goes high.
- npc_sel = 01 with br_taken = 0 behaves exactly like 00.

Test Plan:
- Sequential fetch: release reset, ROM words 0..3 = 0x11,0x22,0x33,0x44 -> rom_addr 0,1,2,3. On edges 1..4: instr_d = 0x11..0x44, pc_d = 0x3000..0x300C, valid_d = 1, fetch_cnt = 4.
- Taken branch: beq with imm16 = 0xFFFF at 0x3004 in ID, br_taken = 1 -> delay slot from 0x3008 enters IF/ID, then pc_f = 0x3004.
- Jump and jr: j with index 0x0000C10 -> pc_f = 0x0000_3040. jr with jr_target = 0x3100 -> pc_f = 0x3100, rom_addr = 0x040.
- Stall/flush: stall for 3 cycles -> pc_f and IF/ID unchanged, fetch_cnt frozen. stall and flush together -> pc_f held, instr_d = 0, valid_d = 0.
- Out of range: jr_target = 0x4000 -> fetch_err = 1, instr_d = 0, valid_d = 0, fetch_cnt unchanged. jr_target = 0x3002 -> fetch_err = 1.
- Async reset: assert reset low mid-cycle with pc_f = 0x3020 -> pc_f = 0x3000, valid_d = 0, fetch_cnt = 0 before the next clock edge.
